// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and helpers for the power-on / reset sequencer.
//   seq_state_t : sequencer FSM encoding, also exported on seq_state
//                 (the unused code 3 is treated as HOLD by the FSM).
//   clog2_min1  : counter width helper that never returns less than 1 bit.
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  // Width needed to count 0..value-1, with a floor of one bit so that
  // degenerate parameters (value of 1 or 2) still give a legal vector.
  function automatic int clog2_min1(input int value);
    int result;
    if (value <= 2) begin
      result = 1;
    end else begin
      result = $clog2(value);
    end
    return result;
  endfunction

endpackage : reset_seq_pkg

// File: rtl/rst_deglitch.sv
// -----------------------------------------------------------------------------
// rst_deglitch
// Synchronises the raw active-low reset pad into the clk domain and applies a
// symmetric run-length filter: the filtered level only follows the synced pad
// once it has disagreed for GLITCH_CYC consecutive samples.
// Ports:
//   clk     in  : clock
//   rst     in  : synchronous active-high reset (filtered level forced to 0)
//   pad     in  : raw pad level, asynchronous to clk
//   pad_ok  out : registered filtered pad level (1 = pad released)
//   pad_bad out : registered complement of pad_ok
// -----------------------------------------------------------------------------
module rst_deglitch
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic pad_ok,
  output logic pad_bad
);

  localparam int            GW          = clog2_min1(GLITCH_CYC);
  localparam logic [GW-1:0] GLITCH_ZERO = GW'(0);
  localparam logic [GW-1:0] GLITCH_ONE  = GW'(1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [GW-1:0]          glitch_cnt_q, glitch_cnt_d;
  logic                   pad_ok_q, pad_ok_d;
  logic                   pad_bad_q, pad_bad_d;
  logic                   s;

  // Oldest synchroniser stage is the only one considered metastability-safe.
  assign s = sync_q[SYNC_STAGES-1];

  // Next state of the synchroniser chain and the run-length filter.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], pad};
    pad_ok_d     = pad_ok_q;
    glitch_cnt_d = GLITCH_ZERO;
    if (s == pad_ok_q) begin
      // Agreement breaks any run in progress.
      glitch_cnt_d = GLITCH_ZERO;
    end else if (glitch_cnt_q == GLITCH_LAST) begin
      // This sample completes a run of GLITCH_CYC disagreeing samples.
      pad_ok_d     = s;
      glitch_cnt_d = GLITCH_ZERO;
    end else begin
      glitch_cnt_d = glitch_cnt_q + GLITCH_ONE;
    end
    pad_bad_d = ~pad_ok_d;
  end

  // Register bank for the synchroniser, filter counter and filtered level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= {SYNC_STAGES{1'b0}};
      glitch_cnt_q <= GLITCH_ZERO;
      pad_ok_q     <= 1'b0;
      pad_bad_q    <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      glitch_cnt_q <= glitch_cnt_d;
      pad_ok_q     <= pad_ok_d;
      pad_bad_q    <= pad_bad_d;
    end
  end

  assign pad_ok  = pad_ok_q;
  assign pad_bad = pad_bad_q;

endmodule : rst_deglitch

// File: rtl/reset_seq_por.sv
// -----------------------------------------------------------------------------
// reset_seq_por
// Power-on / reset sequencer. Derives the POR pair from the de-glitched pad,
// then releases N_DOM active-low domain resets in order (domain 0 first),
// STRETCH cycles apart, after a minimum hold of STRETCH cycles. A software
// request or a pad assertion drops every domain back into the hold phase;
// the software request never touches the POR pair.
// Ports:
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   PAD        in  : raw active-low reset pad, asynchronous to clk
//   sw_rst_req in  : software reset request (level, one cycle suffices)
//   dom_rstb   out : per-domain active-low resets [N_DOM-1:0]
//   porb_l     out : filtered pad level (1 = not in POR)
//   por_l      out : complement of porb_l
//   seq_done   out : all domains released
//   seq_state  out : FSM state (0 HOLD, 1 RELEASE, 2 RUN)
// -----------------------------------------------------------------------------
module reset_seq_por
  import reset_seq_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 4,
  parameter int STRETCH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PAD,
  input  logic             sw_rst_req,
  output logic [N_DOM-1:0] dom_rstb,
  output logic             porb_l,
  output logic             por_l,
  output logic             seq_done,
  output logic [1:0]       seq_state
);

  localparam int            CW        = clog2_min1(STRETCH);
  localparam int            IW        = clog2_min1(N_DOM);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STRETCH - 1);
  localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOM - 1);

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_DOM-1:0] dom_rstb_q, dom_rstb_d;
  logic             seq_done_q, seq_done_d;
  logic             pad_ok;
  logic             pad_bad;
  logic             abort;

  rst_deglitch #(
    .SYNC_STAGES (SYNC_STAGES),
    .GLITCH_CYC  (GLITCH_CYC)
  ) u_deglitch (
    .clk     (clk),
    .rst     (rst),
    .pad     (PAD),
    .pad_ok  (pad_ok),
    .pad_bad (pad_bad)
  );

  // Either a POR or a software request pulls released domains back to HOLD.
  assign abort = (!pad_ok) || sw_rst_req;

  // Sequencer next state plus output decode from the upcoming state, so the
  // registered outputs move on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dom_rstb_d = {N_DOM{1'b0}};
    seq_done_d = 1'b0;

    case (state_q)
      ST_RELEASE: begin
        if (abort) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IDX_ONE;
            cnt_d = CNT_ZERO;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        // HOLD, and the unused encoding which behaves as HOLD.
        state_d = ST_HOLD;
        if (sw_rst_req) begin
          // Restart the minimum hold time.
          cnt_d = CNT_ZERO;
        end else if ((cnt_q == CNT_LAST) && pad_ok) begin
          state_d = ST_RELEASE;
          idx_d   = IDX_ZERO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          // Saturated, waiting for the pad.
          cnt_d = cnt_q;
        end
      end
    endcase

    case (state_d)
      ST_RELEASE: begin
        // Thermometer release: every domain up to and including idx.
        for (int j = 0; j < N_DOM; j++) begin
          dom_rstb_d[j] = (j <= int'(idx_d));
        end
        seq_done_d = 1'b0;
      end
      ST_RUN: begin
        dom_rstb_d = {N_DOM{1'b1}};
        seq_done_d = 1'b1;
      end
      default: begin
        dom_rstb_d = {N_DOM{1'b0}};
        seq_done_d = 1'b0;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= CNT_ZERO;
      idx_q      <= IDX_ZERO;
      dom_rstb_q <= {N_DOM{1'b0}};
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dom_rstb_q <= dom_rstb_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign dom_rstb  = dom_rstb_q;
  assign seq_done  = seq_done_q;
  assign seq_state = state_q;
  assign porb_l    = pad_ok;
  assign por_l     = pad_bad;

endmodule : reset_seq_por

// File: tb/tb_reset_seq_por.sv
// -----------------------------------------------------------------------------
// tb_reset_seq_por
// Self-checking bench: a table of directed vectors for the release sequence,
// glitch rejection, aborts and reset; a randomized pad / request phase checked
// every cycle against a timestamp-based reference model; and a short sequence
// on a minimally parameterised instance.
// -----------------------------------------------------------------------------
module tb_reset_seq_por;

  localparam int N_DOM   = 3;
  localparam int SYNC    = 2;
  localparam int GLITCH  = 4;
  localparam int STRETCH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst        = 1'b1;
  logic             pad        = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             sw_small   = 1'b0;
  logic [N_DOM-1:0] dom_rstb;
  logic             porb_l, por_l, seq_done;
  logic [1:0]       seq_state;
  logic [0:0]       s_dom;
  logic             s_porb, s_por, s_done;
  logic [1:0]       s_state;

  reset_seq_por #(
    .N_DOM(N_DOM), .SYNC_STAGES(SYNC), .GLITCH_CYC(GLITCH), .STRETCH(STRETCH)
  ) dut (
    .clk(clk), .rst(rst), .PAD(pad), .sw_rst_req(sw_rst_req),
    .dom_rstb(dom_rstb), .porb_l(porb_l), .por_l(por_l),
    .seq_done(seq_done), .seq_state(seq_state)
  );

  reset_seq_por #(
    .N_DOM(1), .SYNC_STAGES(2), .GLITCH_CYC(1), .STRETCH(2)
  ) dut_small (
    .clk(clk), .rst(rst), .PAD(pad), .sw_rst_req(sw_small),
    .dom_rstb(s_dom), .porb_l(s_porb), .por_l(s_por),
    .seq_done(s_done), .seq_state(s_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad samples delayed through a queue, filtered level flips when the last
  // GLITCH filter samples all disagree with it, and the sequencer is tracked
  // by two timestamps: when the hold started and when releasing started.
  int   m_e = 0;
  logic m_ok = 1'b0;
  logic m_act = 1'b0;
  int   m_t = 0;
  int   m_h = 0;
  logic m_dly[$];
  logic m_win[$];

  task automatic model_edge();
    logic s_pre;
    bit   all_diff;
    m_e++;
    if (rst) begin
      m_dly.delete();
      for (int i = 0; i < SYNC; i++) m_dly.push_back(1'b0);
      m_win.delete();
      m_ok  = 1'b0;
      m_act = 1'b0;
      m_h   = m_e;
    end else begin
      if (m_act) begin
        if (!m_ok || sw_rst_req) begin
          m_act = 1'b0;
          m_h   = m_e;
        end
      end else if (sw_rst_req) begin
        m_h = m_e;
      end else if ((m_e - m_h >= STRETCH) && m_ok) begin
        m_act = 1'b1;
        m_t   = m_e;
      end
      s_pre = m_dly[0];
      m_win.push_back(s_pre);
      if (m_win.size() > GLITCH) void'(m_win.pop_front());
      all_diff = (m_win.size() == GLITCH);
      foreach (m_win[i]) if (m_win[i] == m_ok) all_diff = 1'b0;
      if (all_diff) m_ok = s_pre;
      void'(m_dly.pop_front());
      m_dly.push_back(pad);
    end
  endtask

  task automatic model_check();
    int el, nrel, e_dom, e_done, e_st;
    if (!m_act) begin
      e_dom = 0; e_done = 0; e_st = 0;
    end else begin
      el   = m_e - m_t;
      nrel = el / STRETCH + 1;
      if (nrel > N_DOM) nrel = N_DOM;
      e_dom  = (1 << nrel) - 1;
      e_done = (el >= N_DOM * STRETCH) ? 1 : 0;
      e_st   = (e_done != 0) ? 2 : 1;
    end
    chk("model dom_rstb", 32'(dom_rstb), 32'(e_dom));
    chk("model seq_done", 32'(seq_done), 32'(e_done));
    chk("model seq_state", 32'(seq_state), 32'(e_st));
    chk("model porb_l", 32'(porb_l), 32'(m_ok));
    chk("model por_l", 32'(por_l), 32'(!m_ok));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         n;
    logic       rst;
    logic       pad;
    logic       sw;
    logic [2:0] dom;
    logic       porb;
    logic       done;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int n, input logic r, input logic p, input logic s,
                         input logic [2:0] d, input logic pb, input logic dn,
                         input logic [1:0] st);
    vec_t v;
    v.n = n; v.rst = r; v.pad = p; v.sw = s;
    v.dom = d; v.porb = pb; v.done = dn; v.st = st;
    vecs.push_back(v);
  endtask

  int   run_left;
  logic pad_lvl;

  initial begin
    // Power-up: reset, then pad held high.
    add_vec( 2, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    add_vec( 5, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0); // edge 5
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0); // edge 6 porb
    add_vec( 9, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0); // edge 15
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1); // edge 16
    add_vec(15, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1); // edge 31
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 2'd1); // edge 32
    add_vec(16, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 2'd1); // edge 48
    add_vec(15, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 2'd1); // edge 63
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2); // edge 64
    // Three-cycle pad glitch: nothing moves.
    add_vec( 3, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2);
    add_vec(12, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2);
    // Four-cycle pad low: POR at 6 edges, domains one edge later.
    add_vec( 4, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 2'd2);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);
    // Recovery back to RUN.
    add_vec(15, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1);
    add_vec(47, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 2'd1);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 2'd2);
    // Software request in RUN: POR untouched, 16-cycle hold again.
    add_vec( 1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0);
    add_vec(15, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0);
    add_vec( 1, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1);
    // idx=1 with cnt at its last value, request wins over the advance.
    add_vec(16, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 2'd1);
    add_vec(15, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 2'd1);
    add_vec( 1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0);
    // Block reset in the middle of RELEASE.
    add_vec(16, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1);
    add_vec( 5, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1);
    add_vec( 1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0);

    foreach (vecs[i]) begin
      rst        = vecs[i].rst;
      pad        = vecs[i].pad;
      sw_rst_req = vecs[i].sw;
      repeat (vecs[i].n) tick();
      chk($sformatf("vec%0d dom_rstb", i), 32'(dom_rstb), 32'(vecs[i].dom));
      chk($sformatf("vec%0d porb_l", i), 32'(porb_l), 32'(vecs[i].porb));
      chk($sformatf("vec%0d por_l", i), 32'(por_l), 32'(!vecs[i].porb));
      chk($sformatf("vec%0d seq_done", i), 32'(seq_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d seq_state", i), 32'(seq_state), 32'(vecs[i].st));
    end

    // Randomized pad runs, occasional software requests and block resets.
    rst = 1'b0;
    sw_rst_req = 1'b0;
    run_left = 0;
    pad_lvl = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (run_left == 0) begin
        pad_lvl  = ($urandom_range(0, 2) != 0);
        run_left = pad_lvl ? $urandom_range(1, 160) : $urandom_range(1, 10);
      end
      run_left--;
      pad        = pad_lvl;
      sw_rst_req = ($urandom_range(0, 149) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      tick();
    end

    // Minimal parameter set: N_DOM=1, STRETCH=2, GLITCH_CYC=1.
    rst = 1'b1; pad = 1'b0; sw_rst_req = 1'b0;
    tick();
    chk("small reset dom_rstb", 32'(s_dom), 32'(0));
    chk("small reset por_l", 32'(s_por), 32'(1));
    chk("small reset seq_state", 32'(s_state), 32'(0));
    rst = 1'b0; pad = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("small e%0d porb_l", k), 32'(s_porb), 32'(k >= 3));
      chk($sformatf("small e%0d por_l", k), 32'(s_por), 32'(k < 3));
      chk($sformatf("small e%0d dom_rstb", k), 32'(s_dom), 32'(k >= 4));
      chk($sformatf("small e%0d seq_done", k), 32'(s_done), 32'(k >= 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reset_seq_por
